// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with a per-owner hold limit.
// Grants are registered; every grant is followed by a one-cycle RELEASE before IDLE.
module rr_arb4 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       busy,
    output logic [1:0] owner,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t     state, state_nx;
    logic [1:0] ptr, ptr_nx, owner_nx, win;
    logic [3:0] hcnt, hcnt_nx, gnt_nx;
    logic       busy_nx, to_nx, found, hold_max, exit_grant;

    // First requester at or after the priority pointer, wrapping mod 4.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                win   = ptr + 2'(i);
                found = 1'b1;
            end
        end
    end

    assign hold_max   = (hcnt == 4'(MAX_HOLD));
    assign exit_grant = done || !req[owner] || hold_max;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        hcnt_nx  = hcnt;
        gnt_nx   = gnt;
        busy_nx  = busy;
        owner_nx = owner;
        to_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    gnt_nx   = 4'b0001 << win;
                    busy_nx  = 1'b1;
                    owner_nx = win;
                    hcnt_nx  = 4'd1;
                end
            end
            GRANT: begin
                if (exit_grant) begin
                    state_nx = RELEASE;
                    gnt_nx   = 4'b0000;
                    busy_nx  = 1'b0;
                    ptr_nx   = owner + 2'd1;
                    // DONE or a dropped request wins over expiry on the same edge
                    to_nx    = hold_max && !done && req[owner];
                end else begin
                    hcnt_nx = hcnt + 4'd1;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            hcnt    <= 4'd0;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            owner   <= 2'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            hcnt    <= hcnt_nx;
            gnt     <= gnt_nx;
            busy    <= busy_nx;
            owner   <= owner_nx;
            timeout <= to_nx;
        end
    end

endmodule

// File: tb/tb_rr_arb4.sv
// Directed vector bench for rr_arb4 built with MAX_HOLD = 4.
// Observed word per cycle is {gnt, busy, owner, timeout}.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arb4 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .busy(busy), .owner(owner), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       to;
    } vec_t;

    vec_t tbl[34];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got gnt/busy/owner/to=%b required %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return {gnt, busy, owner, timeout};
    endfunction

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0}; // first grant from reset, ptr 0
        tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}; // done -> release, ptr 1
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0}; // release -> idle
        tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0}; // ptr 2
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0}; // idle holds with no request
        tbl[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0}; // scan 2,3,0
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0}; // owner dropped, ptr 1
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[11] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[12] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0}; // non-owner ignored
        tbl[13] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0}; // ptr wraps to 0
        tbl[14] = '{4'b1001, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0}; // req ignored in release
        tbl[15] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[16] = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}; // ptr 1
        tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}; // done ignored in release
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}; // done ignored in idle
        tbl[19] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0}; // hold cycle 1
        tbl[20] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[21] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[22] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0}; // hold cycle 4
        tbl[23] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1}; // expiry pulse, ptr 3
        tbl[24] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[25] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0}; // scan 3,0,1,2
        tbl[26] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0}; // ptr 3
        tbl[27] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[28] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0}; // scan 3,0,1
        tbl[29] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[30] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[31] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0}; // hcnt = 4
        tbl[32] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0}; // done beats expiry
        tbl[33] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};

        // Reset state, applied before any clock edge.
        #2;
        check("reset_state", obs(), 8'b0000_0_00_0);
        do_reset();
        check("after_reset_idle", obs(), 8'b0000_0_00_0);

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].done);
            check($sformatf("vec%0d", i), obs(),
                  {tbl[i].gnt, tbl[i].busy, tbl[i].owner, tbl[i].to});
        end

        // Full rotation with requests held and DONE on every third grant cycle.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            logic [1:0] eo;
            eo = 2'(k % 4);
            eg = 4'b0001 << eo;
            step(4'b1111, 1'b0);
            check($sformatf("rot%0d_grant", k), obs(), {eg, 1'b1, eo, 1'b0});
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b0);
            check($sformatf("rot%0d_hold", k), obs(), {eg, 1'b1, eo, 1'b0});
            step(4'b1111, 1'b1);
            check($sformatf("rot%0d_release", k), obs(), {4'b0000, 1'b0, eo, 1'b0});
            step(4'b1111, 1'b0);
            check($sformatf("rot%0d_idle", k), obs(), {4'b0000, 1'b0, eo, 1'b0});
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(4'b0010, 1'b0);
        check("pre_rst_grant", obs(), 8'b0010_1_01_0);
        rst = 1'b1;
        #1;
        check("async_rst_drop", obs(), 8'b0000_0_00_0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0110, 1'b0);
        check("post_rst_grant", obs(), 8'b0010_1_01_0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
